// File: rtl/seq_detector_param.sv
// seq_detector_param
//
// Runtime-programmable serial pattern detector. A one-bit stream is compared
// against a pattern of 1..N bits, either overlapping or non-overlapping. The
// reset configuration is the classic 4-bit "0110" overlapping detector.
//
// Parameters
//   N      maximum pattern length (N >= 4)
//   CNT_W  width of the saturating match counter
//   LW     width of the length fields, $clog2(N+1); leave at its default
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   x            serial data bit
//   in_valid     x carries a sample this cycle
//   cfg_load     latch cfg_pattern/cfg_len/cfg_overlap and clear history
//   cfg_pattern  pattern bits, cfg_pattern[L-1] arrives first, [0] last
//   cfg_len      pattern length L (0 -> 1, > N -> N)
//   cfg_overlap  1: overlapping detection, 0: non-overlapping
//   cnt_clr      synchronous clear of match_cnt (wins over a match)
//   z            combinational Mealy match on the final pattern bit
//   z_q          z delayed by one cycle
//   match_cnt    saturating number of matches
module seq_detector_param #(
  parameter int N     = 8,
  parameter int CNT_W = 8,
  parameter int LW    = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] match_cnt
);

  logic [N-1:0]     pat;
  logic [LW-1:0]    len;
  logic             ovl;
  logic [N-2:0]     hist;
  logic [LW-1:0]    fill;
  logic [CNT_W-1:0] cnt;
  logic             z_r;

  logic [N-1:0]     window;
  logic [N-1:0]     len_mask;
  logic             deep_enough;
  logic             pat_hit;

  // A zero length would leave nothing to compare, so it is promoted to 1;
  // anything longer than the history can hold is cut back to N.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l == '0) begin
      return LW'(1);
    end
    if (int'(l) > N) begin
      return LW'(N);
    end
    return l;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == '1) begin
      return c;
    end
    return c + CNT_W'(1);
  endfunction

  function automatic logic [LW-1:0] fill_inc(input logic [LW-1:0] f);
    if (f == LW'(N - 1)) begin
      return f;
    end
    return f + LW'(1);
  endfunction

  // ---- match evaluation (combinational, same cycle as x) ----
  // The full N-bit window is always formed; a low-order mask of len bits
  // selects the part that takes part in the comparison. When len == N the
  // shift wraps to zero and the subtraction yields all ones.
  always_comb begin
    window      = {hist, x};
    len_mask    = (N'(1) << len) - N'(1);
    deep_enough = (fill >= (len - LW'(1)));
    pat_hit     = (((window ^ pat) & len_mask) == '0);
    z           = in_valid & ~cfg_load & deep_enough & pat_hit;
  end

  // ---- configuration registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat <= N'(4'b0110);
      len <= LW'(4);
      ovl <= 1'b1;
    end else if (cfg_load) begin
      pat <= cfg_pattern;
      len <= clamp_len(cfg_len);
      ovl <= cfg_overlap;
    end
  end

  // ---- history and effective depth ----
  // After a non-overlapping match fill drops to 0 so the bits already in
  // hist are ignored and a complete fresh pattern is required.
  always_ff @(posedge clk) begin
    if (!rst_n || cfg_load) begin
      hist <= '0;
      fill <= '0;
    end else if (in_valid) begin
      hist <= {hist[N-3:0], x};
      if (z && !ovl) begin
        fill <= '0;
      end else begin
        fill <= fill_inc(fill);
      end
    end
  end

  // ---- match counter and registered pulse ----
  always_ff @(posedge clk) begin
    if (!rst_n || cfg_load) begin
      cnt <= '0;
      z_r <= 1'b0;
    end else begin
      z_r <= z;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (z) begin
        cnt <= sat_inc(cnt);
      end
    end
  end

  assign z_q       = z_r;
  assign match_cnt = cnt;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  localparam int N  = 8;
  localparam int LW = $clog2(N + 1);

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          x = 1'b0;
  logic          in_valid = 1'b0;
  logic          cfg_load = 1'b0;
  logic [N-1:0]  cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_overlap = 1'b0;
  logic          cnt_clr = 1'b0;

  logic          z, z_q;
  logic [7:0]    match_cnt;
  logic          z2, z_q2;
  logic [1:0]    match_cnt2;

  seq_detector_param #(.N(N), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z), .z_q(z_q), .match_cnt(match_cnt)
  );

  seq_detector_param #(.N(N), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z2), .z_q(z_q2), .match_cnt(match_cnt2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: accepted bits since the last reset/load/non-overlap
  // match, oldest first, plus the active configuration.
  bit           q[$];
  logic [N-1:0] m_pat;
  int           m_len;
  bit           m_ovl;
  int           m_cnt;
  int           m_cnt2;
  bit           m_zq;

  typedef struct {
    logic  r;
    logic  xi;
    logic  v;
    logic  ld;
    logic  clr;
    int    ez;
    string nm;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit model_z();
    int n;
    if (!in_valid || cfg_load) return 1'b0;
    n = q.size();
    if (n < m_len - 1) return 1'b0;
    if (x != m_pat[0]) return 1'b0;
    for (int i = 1; i < m_len; i++) begin
      if (q[n-i] != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_update(input bit zm);
    if (!rst_n) begin
      m_pat  = 8'b0000_0110;
      m_len  = 4;
      m_ovl  = 1'b1;
      q.delete();
      m_cnt  = 0;
      m_cnt2 = 0;
      m_zq   = 1'b0;
    end else if (cfg_load) begin
      m_pat  = cfg_pattern;
      m_len  = (cfg_len == 0) ? 1 : ((int'(cfg_len) > N) ? N : int'(cfg_len));
      m_ovl  = cfg_overlap;
      q.delete();
      m_cnt  = 0;
      m_cnt2 = 0;
      m_zq   = 1'b0;
    end else begin
      m_zq = zm;
      if (in_valid) begin
        if (zm && !m_ovl) begin
          q.delete();
        end else begin
          q.push_back(x);
          if (q.size() > N - 1) void'(q.pop_front());
        end
      end
      if (cnt_clr) begin
        m_cnt  = 0;
        m_cnt2 = 0;
      end else if (zm) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  // One clock cycle: inputs applied at the falling edge, z checked 1 ns
  // later, registered outputs checked at the next falling edge.
  // ez < 0 means "no fixed expectation, model only".
  task automatic step(input logic r, input logic xi, input logic v, input logic ld,
                      input logic clr, input int ez, input string nm);
    bit zm;
    rst_n    = r;
    x        = xi;
    in_valid = v;
    cfg_load = ld;
    cnt_clr  = clr;
    #1;
    zm = model_z();
    check({nm, " z"}, 32'(z), 32'(zm));
    check({nm, " z2"}, 32'(z2), 32'(zm));
    if (ez >= 0) check({nm, " z_exp"}, 32'(z), 32'(ez));
    @(posedge clk);
    model_update(zm);
    @(negedge clk);
    check({nm, " z_q"}, 32'(z_q), 32'(m_zq));
    check({nm, " cnt"}, 32'(match_cnt), 32'(m_cnt));
    check({nm, " cnt2"}, 32'(match_cnt2), 32'(m_cnt2));
  endtask

  task automatic smp(input logic xi, input int ez, input string nm);
    step(1'b1, xi, 1'b1, 1'b0, 1'b0, ez, nm);
  endtask

  task automatic idle(input string nm);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, nm);
  endtask

  task automatic load(input logic [N-1:0] p, input logic [LW-1:0] l, input logic o);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, "load");
  endtask

  task automatic add(input logic r, input logic xi, input logic v, input logic ld,
                     input logic clr, input int ez, input string nm);
    vec_t e;
    e.r = r; e.xi = xi; e.v = v; e.ld = ld; e.clr = clr; e.ez = ez; e.nm = nm;
    tbl.push_back(e);
  endtask

  initial begin
    // Test 1: reset defaults, overlapping 0110.
    add(0, 0, 0, 0, 0, 0, "rst0");
    add(0, 0, 0, 0, 0, 0, "rst1");
    add(1, 0, 1, 0, 0, 0, "t1 s1");
    add(1, 1, 1, 0, 0, 0, "t1 s2");
    add(1, 1, 1, 0, 0, 0, "t1 s3");
    add(1, 0, 1, 0, 0, 1, "t1 s4");
    add(1, 1, 1, 0, 0, 0, "t1 s5");
    add(1, 1, 1, 0, 0, 0, "t1 s6");
    add(1, 0, 1, 0, 0, 1, "t1 s7");

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].xi, tbl[i].v, tbl[i].ld, tbl[i].clr, tbl[i].ez, tbl[i].nm);
      if (i == 1) begin
        check("reset z_q", 32'(z_q), 0);
        check("reset cnt", 32'(match_cnt), 0);
      end
    end
    check("t1 z_q after s7", 32'(z_q), 1);
    check("t1 cnt", 32'(match_cnt), 2);

    // Test 2: non-overlapping 0110.
    load(8'b0110, 4'd4, 1'b0);
    smp(0, 0, "t2 s1"); smp(1, 0, "t2 s2"); smp(1, 0, "t2 s3"); smp(0, 1, "t2 s4");
    smp(1, 0, "t2 s5"); smp(1, 0, "t2 s6"); smp(0, 0, "t2 s7");
    check("t2 cnt", 32'(match_cnt), 1);
    smp(0, 0, "t2 s8"); smp(1, 0, "t2 s9"); smp(1, 0, "t2 s10"); smp(0, 1, "t2 s11");
    check("t2 cnt2nd", 32'(match_cnt), 2);

    // Test 3: length extremes.
    load(8'b1, 4'd1, 1'b1);
    smp(1, 1, "t3a s1"); smp(1, 1, "t3a s2"); smp(0, 0, "t3a s3"); smp(1, 1, "t3a s4");
    load(8'b1011_0011, 4'd8, 1'b1);
    smp(1, 0, "t3b 1"); smp(0, 0, "t3b 2"); smp(1, 0, "t3b 3"); smp(1, 0, "t3b 4");
    smp(0, 0, "t3b 5"); smp(0, 0, "t3b 6"); smp(1, 0, "t3b 7"); smp(1, 1, "t3b 8");
    check("t3b cnt", 32'(match_cnt), 1);
    load(8'b0000_0001, 4'd0, 1'b1);
    smp(0, 0, "t3c 1"); smp(1, 1, "t3c 2");
    load(8'b1011_0011, 4'd15, 1'b1);
    smp(1, 0, "t3d 1"); smp(0, 0, "t3d 2"); smp(1, 0, "t3d 3"); smp(1, 0, "t3d 4");
    smp(0, 0, "t3d 5"); smp(0, 0, "t3d 6"); smp(1, 0, "t3d 7"); smp(1, 1, "t3d 8");

    // Test 4: gaps are transparent.
    load(8'b0110, 4'd4, 1'b1);
    smp(0, 0, "t4 b1"); idle("t4 i"); idle("t4 i"); idle("t4 i");
    smp(1, 0, "t4 b2"); idle("t4 i"); idle("t4 i"); idle("t4 i");
    smp(1, 0, "t4 b3"); idle("t4 i"); idle("t4 i"); idle("t4 i");
    smp(0, 1, "t4 b4"); idle("t4 i");

    // Test 5: saturation and clear-wins.
    load(8'b1, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) smp(1, 1, "t5 m");
    check("t5 cnt", 32'(match_cnt), 5);
    check("t5 cnt2 sat", 32'(match_cnt2), 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, "t5 clr");
    check("t5 clr cnt", 32'(match_cnt), 0);
    check("t5 clr cnt2", 32'(match_cnt2), 0);

    // Test 6a: reset mid-stream discards progress.
    load(8'b0110, 4'd4, 1'b1);
    smp(0, 0, "t6a 1"); smp(1, 0, "t6a 2"); smp(1, 0, "t6a 3");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "t6a rst");
    smp(0, 0, "t6a 4");
    // Test 6b: load with a simultaneous sample discards it and clears history.
    smp(1, 0, "t6b pre"); smp(0, 0, "t6b 1"); smp(1, 0, "t6b 2"); smp(1, 0, "t6b 3");
    cfg_pattern = 8'b0110; cfg_len = 4'd4; cfg_overlap = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "t6b ld");
    smp(0, 0, "t6b 4"); smp(1, 0, "t6b 5"); smp(1, 0, "t6b 6"); smp(0, 1, "t6b 7");

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel == 0) begin
        step(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0, -1, "rnd rst");
      end else if (sel < 3) begin
        cfg_pattern = N'($urandom);
        cfg_len     = LW'($urandom_range(0, 15));
        cfg_overlap = 1'($urandom);
        step(1'b1, 1'($urandom), 1'($urandom), 1'b1, 1'($urandom), -1, "rnd ld");
      end else begin
        step(1'b1, 1'($urandom), ($urandom_range(0, 3) != 0),
             1'b0, ($urandom_range(0, 39) == 0), -1, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
